// File: rtl/zero_scan_pkg.sv
// Shared types and sizing helpers for the chunked all-zeroes scanner.
package zero_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } zs_state_e;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Result index must also encode "no non-zero chunk" as num_chunks itself.
    function automatic int idx_width(input int width, input int chunk);
        return $clog2(num_chunks(width, chunk) + 1);
    endfunction

endpackage

// File: rtl/zero_scan_ctrl_det.sv
// Narrow all-zeroes detector, reused every cycle by the scan sequencer.
module AllZeroDet #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    output logic             zero_o
);

    assign zero_o = ~|a_i;

endmodule

// File: rtl/zero_scan_ctrl.sv
// Decides A == 0 for a wide operand by scanning one chunk per cycle, LSB chunk
// first, stopping at the first non-zero chunk.
module zero_scan_ctrl
    import zero_scan_pkg::*;
#(
    parameter  int width     = 64,
    parameter  int chunk     = 8,
    localparam int NumChunks = num_chunks(width, chunk),
    localparam int IdxW      = idx_width(width, chunk),
    localparam int PadW      = NumChunks * chunk
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             Z_o,
    output logic [IdxW-1:0]  idx_o
);

    zs_state_e       state_q, state_d;
    logic [IdxW-1:0] counter_q, counter_d;
    logic [PadW-1:0] operand_q, operand_d;
    logic            z_q, z_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [chunk-1:0] chunk_sel;
    logic            chunk_zero;

    // Handshake outputs decode the state register directly, so reset drops
    // out_valid_o without waiting for a clock edge.
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign Z_o         = z_q;
    assign idx_o       = idx_q;

    always_comb begin
        // NOTE: every combinational output gets a default first; without it a
        // path that skips an assignment would infer a latch.
        chunk_sel = '0;
        for (int i = 0; i < NumChunks; i++) begin
            if (counter_q == IdxW'(i)) chunk_sel = operand_q[i*chunk +: chunk];
        end
    end

    AllZeroDet #(.width(chunk)) u_det (
        .a_i    (chunk_sel),
        .zero_o (chunk_zero)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        operand_d = operand_q;
        z_d       = z_q;
        idx_d     = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    operand_d = PadW'(A_i);
                    counter_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!chunk_zero) begin
                    z_d     = 1'b0;
                    idx_d   = counter_q;
                    state_d = DONE;
                end else if (counter_q == IdxW'(NumChunks - 1)) begin
                    z_d     = 1'b1;
                    idx_d   = IdxW'(NumChunks);
                    state_d = DONE;
                end else begin
                    counter_d = counter_q + IdxW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            counter_q <= '0;
            operand_q <= '0;
            z_q       <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            operand_q <= operand_d;
            z_q       <= z_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_zero_scan_ctrl.sv
// Scoreboard bench for zero_scan_ctrl: a 64/8 instance and a 20/8 instance.
module tb_zero_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_z;
    logic [63:0] a_a = '0;
    logic [3:0]  a_idx;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_z;
    logic [19:0] b_a = '0;
    logic [1:0]  b_idx;

    zero_scan_ctrl #(.width(64), .chunk(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .A_i(a_a),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .Z_o(a_z), .idx_o(a_idx)
    );

    zero_scan_ctrl #(.width(20), .chunk(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .A_i(b_a),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .Z_o(b_z), .idx_o(b_idx)
    );

    // lat = clock edges from the accepting edge to the edge that raises out_valid,
    // i.e. the number of chunks scanned (out_valid high in cycle T+lat+1).
    typedef struct {
        logic z;
        int   idx;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic exp_t mk(input logic z, input int idx, input int lat);
        exp_t r;
        r.z = z; r.idx = idx; r.lat = lat;
        return r;
    endfunction

    // Reference for the 64/8 instance: lowest set bit decides the chunk.
    function automatic exp_t model64(input logic [63:0] v);
        exp_t r;
        int   b;
        r = mk(1'b1, 8, 8);
        if (v != 64'h0) begin
            b = 0;
            while (!v[b]) b++;
            r = mk(1'b0, b / 8, b / 8 + 1);
        end
        return r;
    endfunction

    task automatic run_a(input logic [63:0] v, input exp_t e, input int hold, input string name);
        exp_t got;
        int   lat;
        bit   seen;
        sb.push_back(e);
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s idle_ready: got %b want 1", name, a_in_ready);
        end
        a_a = v;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_in_ready, a_out_valid} !== 2'b00) begin
            n_err++; $display("FAIL %s scan_handshake: got %b want 00", name, {a_in_ready, a_out_valid});
        end
        lat = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (a_out_valid === 1'b1) seen = 1;
        end
        a_in_valid = 1'b0;
        got = sb.pop_front();
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL %s timeout: no out_valid after %0d edges", name, lat);
            return;
        end
        if (a_z !== got.z) begin
            n_err++; $display("FAIL %s z: got %b want %b", name, a_z, got.z);
        end
        n_cmp++;
        if (a_idx !== 4'(got.idx)) begin
            n_err++; $display("FAIL %s idx: got %0d want %0d", name, a_idx, got.idx);
        end
        n_cmp++;
        if (lat != got.lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({a_out_valid, a_in_ready, a_z, a_idx} !== {1'b1, 1'b0, got.z, 4'(got.idx)}) begin
                n_err++;
                $display("FAIL %s hold%0d: got v=%b r=%b z=%b idx=%0d want v=1 r=0 z=%b idx=%0d",
                         name, i, a_out_valid, a_in_ready, a_z, a_idx, got.z, got.idx);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_err++; $display("FAIL %s after_handshake: got v=%b r=%b want v=0 r=1", name, a_out_valid, a_in_ready);
        end
        n_cmp++;
        if ({a_z, a_idx} !== {got.z, 4'(got.idx)}) begin
            n_err++; $display("FAIL %s result_held: got z=%b idx=%0d want z=%b idx=%0d", name, a_z, a_idx, got.z, got.idx);
        end
    endtask

    task automatic run_b(input logic [19:0] v, input exp_t e, input string name);
        exp_t got;
        int   lat;
        bit   seen;
        sb.push_back(e);
        @(negedge clk);
        b_a = v;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (b_out_valid === 1'b1) seen = 1;
        end
        b_in_valid = 1'b0;
        got = sb.pop_front();
        n_cmp++;
        if (!seen || {b_z, b_idx} !== {got.z, 2'(got.idx)} || lat != got.lat) begin
            n_err++;
            $display("FAIL %s: got seen=%0d z=%b idx=%0d lat=%0d want z=%b idx=%0d lat=%0d",
                     name, seen, b_z, b_idx, lat, got.z, got.idx, got.lat);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        n_cmp++;
        if ({b_out_valid, b_in_ready} !== 2'b01) begin
            n_err++; $display("FAIL %s after_handshake: got v=%b r=%b want v=0 r=1", name, b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_z, a_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL reset_a: got r=%b v=%b z=%b idx=%0d want r=1 v=0 z=0 idx=0",
                              a_in_ready, a_out_valid, a_z, a_idx);
        end
        n_cmp++;
        if ({b_in_ready, b_out_valid, b_z, b_idx} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL reset_b: got r=%b v=%b z=%b idx=%0d want r=1 v=0 z=0 idx=0",
                              b_in_ready, b_out_valid, b_z, b_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_a(64'h0, mk(1'b1, 8, 8), 0, "all_zero");
        run_a(64'h1, mk(1'b0, 0, 1), 0, "early_exit");
        run_a(64'h0100_0000_0000_0000, mk(1'b0, 7, 8), 0, "top_chunk");
        run_a(64'h8000_0000_0000_0000, mk(1'b0, 7, 8), 0, "msb_only");
    endtask

    task automatic test_backpressure();
        run_a(64'h0000_0000_00FF_0000, mk(1'b0, 2, 3), 5, "backpressure");
        run_a(64'h0, mk(1'b1, 8, 8), 5, "backpressure_zero");
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        int          p;
        for (int n = 0; n < 8; n++) begin
            p = $urandom_range(0, 8);
            v = {$urandom, $urandom};
            v[7:0] = v[7:0] | 8'h01;
            v = (p == 8) ? 64'h0 : (v << (p * 8));
            run_a(v, model64(v), 0, $sformatf("b2b%0d", n));
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        a_a = 64'h0;
        a_in_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        a_in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_z, a_idx} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL reset_scan: got v=%b r=%b z=%b idx=%0d want v=0 r=1 z=0 idx=0",
                              a_out_valid, a_in_ready, a_z, a_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_scan_no_result: got v=%b want 0", a_out_valid);
        end
        run_a(64'h1, mk(1'b0, 0, 1), 0, "after_reset");
    endtask

    task automatic test_reset_in_done();
        @(negedge clk);
        a_a = 64'h0000_0000_0000_0100;
        a_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_z, a_idx} !== {1'b1, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL pre_reset_done: got v=%b z=%b idx=%0d want v=1 z=0 idx=1", a_out_valid, a_z, a_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_err++; $display("FAIL reset_done_async: got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_partial_chunk();
        run_b(20'h80000, mk(1'b0, 2, 3), "w20_top_bit");
        run_b(20'h00000, mk(1'b1, 3, 3), "w20_zero");
        run_b(20'h00100, mk(1'b0, 1, 2), "w20_mid");
        run_b(20'h00001, mk(1'b0, 0, 1), "w20_early");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        test_reset_in_done();
        test_partial_chunk();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
